// File: rtl/instruction_pkg.sv
// Shared operation codes, multiply/divide FSM states and op classification.
package instruction_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_XOR    = 5'd2,
    OP_OR     = 5'd3,
    OP_AND    = 5'd4,
    OP_SLL    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_SLT    = 5'd8,
    OP_SLTU   = 5'd9,
    OP_MUL    = 5'd10,
    OP_MULH   = 5'd11,
    OP_MULHSU = 5'd12,
    OP_MULHU  = 5'd13,
    OP_DIV    = 5'd14,
    OP_DIVU   = 5'd15,
    OP_REM    = 5'd16,
    OP_REMU   = 5'd17
  } alu_op_e;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_e;

  // Ops that go through the iterative engine instead of the 1-cycle ALU.
  function automatic logic is_muldiv(input logic [4:0] op);
    return (op >= 5'd10) && (op <= 5'd17);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes.
// Cycle 0 after start forms magnitudes, then DATA_WIDTH iterations run;
// signs and the divide-by-zero / overflow cases are resolved on the output.
module muldiv_iter
  import instruction_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  start,
  input  logic                  run,
  input  logic [4:0]            op,
  input  logic [DATA_WIDTH-1:0] rs1,
  input  logic [DATA_WIDTH-1:0] rs2,
  output logic                  last,
  output logic [DATA_WIDTH-1:0] result
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;

  logic [4:0]     op_q;
  logic [W-1:0]   a_q, b_q, a_abs, b_abs;
  logic [2*W-1:0] acc, acc_step, prod;
  logic [CW-1:0]  cnt;
  logic           a_sgn, b_sgn, is_mul, div0, ovf, div_ge;
  logic [W:0]     mul_sum, div_sh;
  logic [W+1:0]   div_diff;
  logic [W-1:0]   quo, rem;

  assign is_mul = (op_q <= OP_MULHU);
  assign a_sgn  = ((op_q == OP_MULH) || (op_q == OP_MULHSU) ||
                   (op_q == OP_DIV)  || (op_q == OP_REM)) && a_q[W-1];
  assign b_sgn  = ((op_q == OP_MULH) || (op_q == OP_DIV) ||
                   (op_q == OP_REM)) && b_q[W-1];
  assign a_abs  = a_sgn ? -a_q : a_q;
  assign b_abs  = b_sgn ? -b_q : b_q;
  assign last   = run && (cnt == CW'(W));

  // One multiply (add-then-shift) or divide (shift-then-subtract) step.
  always_comb begin
    mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, b_abs} : '0);
    div_sh   = {acc[2*W-1:W], acc[W-1]};
    div_diff = {1'b0, div_sh} - {2'b0, b_abs};
    div_ge   = !div_diff[W+1];
    acc_step = is_mul ? {mul_sum, acc[W-1:1]}
                      : {(div_ge ? div_diff[W-1:0] : div_sh[W-1:0]), acc[W-2:0], div_ge};
  end

  // Operand latch, iteration counter and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0; a_q <= '0; b_q <= '0; acc <= '0; cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (start) begin
      op_q <= op; a_q <= rs1; b_q <= rs2; cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
      acc <= (cnt == '0) ? {{W{1'b0}}, a_abs} : acc_step;
    end
  end

  // Sign post-correction and special cases.
  always_comb begin
    prod = (a_sgn ^ b_sgn) ? -acc : acc;
    quo  = (a_sgn ^ b_sgn) ? -acc[W-1:0] : acc[W-1:0];
    rem  = a_sgn ? -acc[2*W-1:W] : acc[2*W-1:W];
    div0 = (b_q == '0);
    ovf  = ((op_q == OP_DIV) || (op_q == OP_REM)) &&
           (a_q == {1'b1, {(W-1){1'b0}}}) && (&b_q);
    case (op_q)
      OP_MUL:                       result = prod[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod[2*W-1:W];
      OP_DIV, OP_DIVU:              result = div0 ? '1 : ovf ? {1'b1, {(W-1){1'b0}}} : quo;
      OP_REM, OP_REMU:              result = div0 ? a_q : ovf ? '0 : rem;
      default:                      result = '0;
    endcase
  end

endmodule

// File: rtl/alu_md_unit.sv
// Integer execution unit: 1-cycle ALU, registered output with valid/ready,
// ROB tag passthrough. Define ALU_MULDIV_EN to build in the iterative
// multiply/divide engine (BUSY/DONE states); otherwise M codes return 0.
module alu_md_unit
  import instruction_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            in_op,
  input  logic [DATA_WIDTH-1:0] in_rs1,
  input  logic [DATA_WIDTH-1:0] in_rs2,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  out_zero
);
  localparam int SW = $clog2(DATA_WIDTH);

  md_state_e             state_q, state_d;
  logic                  out_free, accept, is_md, md_last, load_alu, load_md;
  logic [SW-1:0]         shamt;
  logic [DATA_WIDTH-1:0] alu_res, md_result, load_val;
  logic [TAG_WIDTH-1:0]  md_tag_q, load_tag;

  assign out_free = !out_valid || out_ready;
  assign in_ready = (state_q == IDLE) && out_free && !flush;
  assign accept   = in_valid && in_ready;
  assign load_alu = accept && !is_md;
  assign load_md  = (state_q == DONE) && out_free && !flush;
  assign shamt    = in_rs2[SW-1:0];

`ifdef ALU_MULDIV_EN
  assign is_md = is_muldiv(in_op);

  // Tag rides alongside the engine while it iterates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 md_tag_q <= '0;
    else if (accept && is_md)   md_tag_q <= in_tag;
  end

  muldiv_iter #(.DATA_WIDTH(DATA_WIDTH)) u_md (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .start  (accept && is_md),
    .run    (state_q == BUSY),
    .op     (in_op),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .last   (md_last),
    .result (md_result)
  );
`else
  assign is_md     = 1'b0;
  assign md_last   = 1'b0;
  assign md_result = '0;
  assign md_tag_q  = '0;
`endif

  // Single-cycle ALU; unknown codes (and M codes without the engine) give 0.
  always_comb begin
    case (in_op)
      OP_ADD:  alu_res = in_rs1 + in_rs2;
      OP_SUB:  alu_res = in_rs1 - in_rs2;
      OP_XOR:  alu_res = in_rs1 ^ in_rs2;
      OP_OR:   alu_res = in_rs1 | in_rs2;
      OP_AND:  alu_res = in_rs1 & in_rs2;
      OP_SLL:  alu_res = in_rs1 << shamt;
      OP_SRL:  alu_res = in_rs1 >> shamt;
      OP_SRA:  alu_res = $signed(in_rs1) >>> shamt;
      OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(in_rs1) < $signed(in_rs2)};
      OP_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, in_rs1 < in_rs2};
      default: alu_res = '0;
    endcase
  end

  assign load_val = load_md ? md_result : alu_res;
  assign load_tag = load_md ? md_tag_q  : in_tag;

  // Output register: refill wins over drain; flush and bare drains clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      out_valid <= 1'b0; out_result <= '0; out_tag <= '0; out_zero <= 1'b0;
    end else if (load_alu || load_md) begin
      out_valid  <= 1'b1;
      out_result <= load_val;
      out_tag    <= load_tag;
      out_zero   <= (load_val == '0);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0; out_result <= '0; out_tag <= '0; out_zero <= 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; DONE waits until the output register can take the result.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && is_md) state_d = BUSY;
      BUSY:    if (md_last)         state_d = DONE;
      DONE:    if (load_md)         state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

endmodule

// File: tb/tb_alu_md_unit.sv
// Self-checking bench for alu_md_unit against a plain-arithmetic reference.
module tb_alu_md_unit;
`ifdef ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_zero;
  logic [4:0]  in_op = '0;
  logic [31:0] in_rs1 = '0, in_rs2 = '0, out_result;
  logic [5:0]  in_tag = '0, out_tag;
  int          tests = 0, fails = 0;

  alu_md_unit #(.DATA_WIDTH(32), .TAG_WIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, b);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub, p;
    logic [4:0] sh;
    sa = {{32{a[31]}}, a}; sb = {{32{b[31]}}, b};
    ua = {32'b0, a};       ub = {32'b0, b};
    sh = b[4:0];
    if (!MD && op >= 5'd10 && op <= 5'd17) return 32'h0;
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a ^ b;
      5'd3:  return a | b;
      5'd4:  return a & b;
      5'd5:  return a << sh;
      5'd6:  return a >> sh;
      5'd7:  return 32'($signed(a) >>> sh);
      5'd8:  return {31'b0, $signed(a) < $signed(b)};
      5'd9:  return {31'b0, a < b};
      5'd10: begin p = ua * ub;           return p[31:0];  end
      5'd11: begin p = sa * sb;           return p[63:32]; end
      5'd12: begin p = sa * $signed(ub);  return p[63:32]; end
      5'd13: begin p = ua * ub;           return p[63:32]; end
      5'd14: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'($signed(a) / $signed(b));
      end
      5'd15: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd16: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'($signed(a) % $signed(b));
      end
      5'd17: return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Issue one op with out_ready high and check result, tag, zero flag, latency.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] tag);
    int n, lat;
    logic [31:0] exp;
    exp = model(op, a, b);
    lat = (MD && op >= 5'd10 && op <= 5'd17) ? 34 : 1;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_rs1 = a; in_rs2 = b; in_tag = tag;
    check("issue_ready", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk); n++;
      if (!out_valid && n < lat) check("busy_ready_low", in_ready, 0);
    end while (!out_valid && n < 200);
    check("latency", n, lat);
    check("result", out_result, exp);
    check("tag", out_tag, tag);
    check("zero", out_zero, exp == 0);
  endtask

  initial begin
    logic seen;
    // Reset values
    #3;
    check("rst_valid", out_valid, 0);
    check("rst_result", out_result, 0);
    check("rst_tag", out_tag, 0);
    check("rst_zero", out_zero, 0);
    @(negedge clk); rst_n = 1'b1;
    #1 check("rst_ready", in_ready, 1);

    // Directed ALU cases
    run_op(5'd0, 32'hFFFF_FFFF, 32'h1, 6'd5);
    run_op(5'd4, 32'h0000_F0F0, 32'h0000_0FF0, 6'd1);
    run_op(5'd7, 32'h8000_0000, 32'h21, 6'd2);
    run_op(5'd5, 32'h0000_0003, 32'h21, 6'd3);
    run_op(5'd8, 32'hFFFF_FFFF, 32'h1, 6'd4);
    run_op(5'd9, 32'hFFFF_FFFF, 32'h1, 6'd6);
    run_op(5'd20, 32'h1234_5678, 32'h1, 6'd7);

    // Directed M cases
    run_op(5'd11, 32'h8000_0000, 32'h8000_0000, 6'd8);
    run_op(5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 6'd9);
    run_op(5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 6'd10);
    run_op(5'd15, 32'h7, 32'h0, 6'd11);
    run_op(5'd17, 32'h7, 32'h0, 6'd12);
    run_op(5'd14, 32'hFFFF_FFF9, 32'h2, 6'd13);
    run_op(5'd16, 32'hFFFF_FFF9, 32'h2, 6'd14);

    // Output stall: result and tag hold, in_ready low, pending op not taken
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_op = 5'd0; in_rs1 = 32'h10; in_rs2 = 32'h20; in_tag = 6'd9;
    @(posedge clk); #1;
    in_op = 5'd2; in_rs1 = 32'hFF; in_rs2 = 32'h0F; in_tag = 6'd10;
    repeat (4) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_result", out_result, 32'h30);
      check("stall_tag", out_tag, 9);
      check("stall_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1 check("release_ready", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("refill_valid", out_valid, 1);
    check("refill_result", out_result, 32'hF0);
    check("refill_tag", out_tag, 10);

    // Flush drops a held result and ignores same-cycle in_valid
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_op = 5'd3; in_rs1 = 32'h1; in_rs2 = 32'h2; in_tag = 6'd3;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("pre_flush_valid", out_valid, 1);
    flush = 1'b1; in_valid = 1'b1; in_op = 5'd0;
    #1 check("flush_ready", in_ready, 0);
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("post_flush_valid", out_valid, 0);
    check("post_flush_ready", in_ready, 1);
    out_ready = 1'b1;

`ifdef ALU_MULDIV_EN
    // Flush in the middle of a divide: no result ever appears
    @(negedge clk);
    in_valid = 1'b1; in_op = 5'd14; in_rs1 = 32'd100; in_rs2 = 32'd7; in_tag = 6'd12;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_op = 5'd0; in_rs1 = 32'd1; in_rs2 = 32'd1;
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("div_flush_ready", in_ready, 1);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    check("div_flush_noresult", seen, 0);
`endif
    run_op(5'd0, 32'd2, 32'd3, 6'd15);

    // Reset in the middle of an op: nothing emerges afterwards
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_op = 5'd10; in_rs1 = 32'd6; in_rs2 = 32'd7; in_tag = 6'd20;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_result", out_result, 0);
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    #1 check("midrst_ready", in_ready, 1);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    check("midrst_noresult", seen, 0);

    // Randomized ops with corner-biased operands
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      logic [4:0]  op;
      op = 5'($urandom_range(0, 19));
      case ($urandom_range(0, 4))
        0: a = 32'h0; 1: a = 32'h8000_0000; 2: a = 32'hFFFF_FFFF; default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'h0; 1: b = 32'hFFFF_FFFF; 2: b = 32'h1; 3: b = 32'($urandom_range(0, 63));
        default: b = $urandom;
      endcase
      run_op(op, a, b, 6'($urandom_range(0, 63)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
